// File: rtl/conv_encoder_param.sv
// Block convolutional encoder with N_OUT generator streams.
// A block length is popped from the meta FIFO and the block's words are buffered.
// The block is then encoded DATA_W bits per cycle, either tail-biting or zero-terminated.
module conv_encoder_param #(
    parameter int unsigned        DATA_W    = 8,
    parameter int unsigned        K         = 7,
    parameter int unsigned        N_OUT     = 3,
    parameter logic [N_OUT*K-1:0] GEN       = {7'o133, 7'o171, 7'o165},
    parameter int unsigned        MAX_WORDS = 768,
    parameter int unsigned        LEN_W     = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [LEN_W-1:0]        meta_q,
    input  logic                    meta_empty,
    output logic                    meta_rdreq,
    input  logic [DATA_W-1:0]       data_q,
    input  logic                    data_empty,
    output logic                    data_rdreq,
    input  logic                    tail_bite,
    output logic [N_OUT*DATA_W-1:0] out_q,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int unsigned    AW     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int unsigned    HW     = K - 1;
    localparam logic [LEN_W:0] MaxLen = (LEN_W + 1)'(MAX_WORDS);

    typedef enum logic [2:0] {StIdle, StLoad, StEncode, StTail, StDone} state_e;

    state_e                    state_q, state_d;
    logic [LEN_W-1:0]          len_q, len_d;
    logic                      mode_q, mode_d;
    logic [LEN_W-1:0]          cnt_q, cnt_d;
    logic [HW-1:0]             hist_q, hist_d;
    logic [N_OUT*DATA_W-1:0]   out_data_q, out_data_d;
    logic                      out_valid_q, out_valid_d;
    logic                      out_last_q, out_last_d;
    logic                      err_q, err_d;
    logic                      armed_q;
    logic [DATA_W-1:0]         mem_q [MAX_WORDS];
    logic                      mem_we;

    logic [DATA_W-1:0]         enc_word;
    logic [DATA_W+HW-1:0]      enc_ext;
    logic [HW-1:0]             enc_hist;
    logic [N_OUT*DATA_W-1:0]   enc_out;
    logic [LEN_W-1:0]          last_idx;
    logic                      len_bad;
    logic                      accept;
    logic                      load_en;

    assign last_idx = len_q - LEN_W'(1);
    assign len_bad  = (meta_q == '0) || ({1'b0, meta_q} > MaxLen);
    assign accept   = out_valid_q && out_ready;
    // Output register may take a new word when empty or being drained this cycle.
    assign load_en  = !out_valid_q || out_ready;

    // One word of encoder output: history bits below the word, newest bit on top.
    always_comb begin
        enc_word = (state_q == StTail) ? '0 : mem_q[cnt_q[AW-1:0]];
        enc_ext  = {enc_word, hist_q};
        enc_hist = enc_ext[DATA_W+HW-1 -: HW];
        enc_out  = '0;
        for (int s = 0; s < N_OUT; s++) begin
            for (int i = 0; i < DATA_W; i++) begin
                for (int j = 0; j < K; j++) begin
                    enc_out[s*DATA_W+i] = enc_out[s*DATA_W+i]
                        ^ (GEN[(N_OUT-1-s)*K + K-1-j] & enc_ext[HW+i-j]);
                end
                if ((state_q == StTail) && (i >= HW)) begin
                    enc_out[s*DATA_W+i] = 1'b0;
                end
            end
        end
    end

    // Next-state logic and FIFO pops.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        hist_d      = hist_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        err_d       = 1'b0;
        meta_rdreq  = 1'b0;
        data_rdreq  = 1'b0;
        mem_we      = 1'b0;

        if (accept) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = '0;
        end

        unique case (state_q)
            StIdle: begin
                if (armed_q && !meta_empty) begin
                    meta_rdreq = 1'b1;
                    len_d      = meta_q;
                    mode_d     = tail_bite;
                    cnt_d      = '0;
                    if (len_bad) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                if (!data_empty) begin
                    data_rdreq = 1'b1;
                    mem_we     = 1'b1;
                    cnt_d      = cnt_q + LEN_W'(1);
                    if (cnt_q == last_idx) begin
                        // Tail-biting starts from the block's own final bits.
                        hist_d  = mode_q ? data_q[DATA_W-1 -: HW] : '0;
                        cnt_d   = '0;
                        state_d = StEncode;
                    end
                end
            end
            StEncode: begin
                if (out_last_q) begin
                    if (accept) state_d = StDone;
                end else if (load_en) begin
                    out_data_d  = enc_out;
                    out_valid_d = 1'b1;
                    hist_d      = enc_hist;
                    cnt_d       = cnt_q + LEN_W'(1);
                    if (cnt_q == last_idx) begin
                        cnt_d = '0;
                        if (mode_q) begin
                            out_last_d = 1'b1;
                        end else begin
                            state_d = StTail;
                        end
                    end
                end
            end
            StTail: begin
                if (out_last_q) begin
                    if (accept) state_d = StDone;
                end else if (load_en) begin
                    out_data_d  = enc_out;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b1;
                    hist_d      = enc_hist;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            len_q       <= '0;
            mode_q      <= 1'b0;
            cnt_q       <= '0;
            hist_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            hist_q      <= hist_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
            armed_q     <= 1'b1;
        end
    end

    // Block buffer; contents need no reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[cnt_q[AW-1:0]] <= data_q;
    end

    assign out_q     = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign err       = err_q;

endmodule
